clock_divider_prog: RTL and testbench
=====================================

// Module: clock_divider_prog
// PURPOSE
//   Programmable, glitch-free integer clock divider that feeds clock_buffer.
//   Divides clk_in by a runtime-loadable ratio N and drives a registered clk_out.
//   Ratio changes and start/stop take effect only at period boundaries, so
//   clk_out never carries a runt pulse.
// PARAMETERS
//   WIDTH        8   width of the ratio bus; legal N = 2 .. 2**WIDTH-1
//   DEFAULT_DIV  4   active ratio after reset; must be >= 2
// PORTS
//   clk_in     in   1      source clock; all logic on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   en         in   1      run request; level-sensitive
//   div_ratio  in   WIDTH  requested ratio; sampled only when div_load=1
//   div_load   in   1      1-cycle strobe: capture div_ratio as pending ratio
//   div_ack    out  1      1-cycle pulse: the pending ratio became active
//   clk_out    out  1      divided clock (register output, to clock_buffer)
//   running    out  1      1 while the FSM is in HIGH or LOW
// BEHAVIOUR
//   Reset (async assert, sync release):
//     clk_out=0, div_ack=0, running=0, state=IDLE, cnt=0,
//     active=DEFAULT_DIV, pending_vld=0.
//   Ratio clamp: captured values 0 and 1 are stored as 2.
//   Phase lengths for active ratio N:
//     HIGH lasts ceil(N/2) cycles; LOW lasts floor(N/2) cycles.
//     Period is exactly N clk_in cycles.
//     Duty cycle is 50% for even N; one extra HIGH cycle for odd N.
//   FSM states: IDLE, HIGH, LOW. clk_out=1 iff state==HIGH.
//     IDLE -> HIGH : en=1. clk_out rises on the next edge after en is sampled.
//     HIGH -> LOW  : cnt reaches ceil(N/2)-1; cnt is then cleared.
//     LOW  -> HIGH : cnt reaches floor(N/2)-1 and en=1 (period boundary).
//     LOW  -> IDLE : cnt reaches floor(N/2)-1 and en=0 (period boundary).
//   Stopping: dropping en mid-period never truncates the period. The current
//     HIGH and LOW phases complete, then clk_out stays 0.
//   Ratio load:
//     - div_load=1 captures clamp(div_ratio) into pending and sets pending_vld.
//     - A later div_load before the boundary overwrites pending; there is one
//       ack only, for the last value loaded.
//     - At a period boundary (end of LOW), or on IDLE->HIGH, pending becomes
//       active if pending_vld=1. pending_vld clears and div_ack pulses for 1
//       cycle, coincident with the first clk_out=1 cycle at the new ratio.
//     - A boundary that goes LOW->IDLE also applies pending and pulses div_ack.
//     - In IDLE with en=0, a div_load applies on the next cycle and div_ack
//       pulses then.
//   Simultaneous events: a div_load in the same cycle as a boundary is NOT
//     applied at that boundary. It waits for the next one; the old pending
//     value is discarded.
//   running=1 in the same cycles as HIGH/LOW; it drops with the LOW->IDLE edge.
//   Reset mid-operation: clk_out goes 0 immediately (async), the pending value
//     is lost, and active returns to DEFAULT_DIV.
//   Internal counter: cnt is WIDTH bits wide; it never wraps because each
//     phase is at most 2**(WIDTH-1) cycles.
// TESTING
//   1. Reset, en=1 at DEFAULT_DIV=4 -> clk_out 1,1,0,0 repeating;
//      first rise 1 cycle after en; running=1.
//   2. N=5 loaded while IDLE, en=1 -> div_ack pulse, then clk_out 1,1,1,0,0;
//      period 5, no runt.
//   3. Running at N=4, div_load N=6 mid-HIGH -> current period still 4 cycles;
//      div_ack coincides with first HIGH of 3-high/3-low.
//   4. Two div_loads (8 then 10) in one period -> a single div_ack;
//      the new period is 10.
//   5. div_ratio=0 and =1 -> behaves as N=2 (1,0 toggling).
//   6. en dropped 1 cycle into HIGH at N=6 -> 3 high, 3 low, then clk_out=0
//      and running=0; rst_n pulsed mid-HIGH -> clk_out=0 asynchronously;
//      on restart the divider runs at N=4.

Source files
------------

// File: rtl/clock_divider_prog.sv
// Programmable glitch-free integer clock divider. Ratio changes and start/stop
// are deferred to period boundaries so clk_out never carries a runt pulse.
module clock_divider_prog #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] div_ratio,
   input  logic             div_load,
   output logic             div_ack,
   output logic             clk_out,
   output logic             running
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

   localparam logic [WIDTH:0]   ONE_W = 1;
   localparam logic [WIDTH-1:0] ONE   = 1;
   localparam logic [WIDTH-1:0] TWO   = 2;
   localparam logic [WIDTH-1:0] DEF   = WIDTH'(DEFAULT_DIV);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] active_q, active_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic             pending_vld_q, pending_vld_d;
   logic             clk_out_q, clk_out_d;
   logic             div_ack_q, div_ack_d;
   logic             running_q, running_d;

   logic [WIDTH-1:0] hi_last, lo_last, ratio_clamped;
   logic             boundary;

   // HIGH lasts ceil(N/2) cycles, LOW floor(N/2); widen before +1 so N=2**WIDTH-1 is safe.
   assign hi_last       = WIDTH'(({1'b0, active_q} + ONE_W) >> 1) - ONE;
   assign lo_last       = (active_q >> 1) - ONE;
   assign ratio_clamped = (div_ratio < TWO) ? TWO : div_ratio;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      active_d      = active_q;
      pending_d     = pending_q;
      pending_vld_d = pending_vld_q;
      div_ack_d     = 1'b0;
      boundary      = 1'b0;

      case (state_q)
         IDLE: begin
            boundary = 1'b1;
            if (en) begin
               state_d = HIGH;
               cnt_d   = '0;
            end
         end
         HIGH: begin
            if (cnt_q == hi_last) begin
               state_d = LOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         LOW: begin
            if (cnt_q == lo_last) begin
               boundary = 1'b1;
               state_d  = en ? HIGH : IDLE;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A load coinciding with a boundary wins over applying the older pending value.
      if (div_load) begin
         pending_d     = ratio_clamped;
         pending_vld_d = 1'b1;
      end else if (boundary && pending_vld_q) begin
         active_d      = pending_q;
         pending_vld_d = 1'b0;
         div_ack_d     = 1'b1;
      end

      clk_out_d = (state_d == HIGH);
      running_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         active_q      <= DEF;
         pending_q     <= DEF;
         pending_vld_q <= 1'b0;
         clk_out_q     <= 1'b0;
         div_ack_q     <= 1'b0;
         running_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         active_q      <= active_d;
         pending_q     <= pending_d;
         pending_vld_q <= pending_vld_d;
         clk_out_q     <= clk_out_d;
         div_ack_q     <= div_ack_d;
         running_q     <= running_d;
      end
   end

   assign clk_out = clk_out_q;
   assign div_ack = div_ack_q;
   assign running = running_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog: directed scenarios plus randomized traffic,
// checked against a waveform-queue reference model.
module tb_clock_divider_prog;

   logic       clk_in = 1'b0;
   logic       rst_n  = 1'b0;
   logic       en     = 1'b0;
   logic [7:0] div_ratio = '0;
   logic       div_load  = 1'b0;
   logic       div_ack, clk_out, running;

   int n_tests = 0;
   int n_fail  = 0;

   clock_divider_prog #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .en       (en),
      .div_ratio(div_ratio),
      .div_load (div_load),
      .div_ack  (div_ack),
      .clk_out  (clk_out),
      .running  (running)
   );

   always #5 clk_in = ~clk_in;

   // Reference: each period is materialised as a list of future clk_out values.
   int m_active, m_pend;
   bit m_pvld, m_clk, m_ack, m_run;
   bit wq[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_active = 4; m_pend = 4; m_pvld = 0;
      m_clk = 0; m_ack = 0; m_run = 0;
      wq.delete();
   endtask

   task automatic m_edge(input bit e, input bit ld, input int r);
      int rc;
      rc = (r < 2) ? 2 : r;
      m_ack = 0;
      if (wq.size() == 0) begin
         if (ld) begin m_pend = rc; m_pvld = 1; end
         else if (m_pvld) begin m_active = m_pend; m_pvld = 0; m_ack = 1; end
         if (e) begin
            for (int i = 1; i < m_active; i++) wq.push_back(i < (m_active + 1) / 2);
            m_clk = 1; m_run = 1;
         end else begin
            m_clk = 0; m_run = 0;
         end
      end else begin
         if (ld) begin m_pend = rc; m_pvld = 1; end
         m_clk = wq.pop_front();
         m_run = 1;
      end
   endtask

   task automatic cyc(input bit e, input bit ld, input int r);
      en = e; div_load = ld; div_ratio = r[7:0];
      @(posedge clk_in);
      m_edge(e, ld, r & 255);
      #1;
      chk("clk_out", clk_out, m_clk);
      chk("div_ack", div_ack, m_ack);
      chk("running", running, m_run);
      div_load = 1'b0;
   endtask

   task automatic do_reset();
      en = 0; div_load = 0;
      rst_n = 1'b0;
      #1;
      chk("rst_clk_out", clk_out, 0);
      chk("rst_running", running, 0);
      chk("rst_div_ack", div_ack, 0);
      m_reset();
      @(posedge clk_in);
      #1;
      rst_n = 1'b1;
   endtask

   logic [15:0] seq;
   int acks;
   bit  e_r;

   initial begin
      m_reset();
      @(posedge clk_in); #1;
      do_reset();

      // Default ratio 4, first rise one edge after en.
      seq = '0;
      for (int i = 0; i < 8; i++) begin cyc(1, 0, 0); seq = {seq[14:0], clk_out}; end
      chk("t1_seq", seq[7:0], 8'b11001100);
      chk("t1_running", running, 1);

      // N=5 loaded in IDLE.
      do_reset();
      cyc(0, 1, 5);
      cyc(0, 0, 0);
      chk("t2_idle_ack", div_ack, 1);
      seq = '0;
      for (int i = 0; i < 10; i++) begin cyc(1, 0, 0); seq = {seq[14:0], clk_out}; end
      chk("t2_seq", seq[9:0], 10'b1110011100);

      // Running at 4, load 6 mid-HIGH: current period finishes at 4.
      do_reset();
      cyc(1, 0, 0);
      cyc(1, 1, 6);
      seq = '0;
      for (int i = 0; i < 8; i++) begin cyc(1, 0, 0); seq = {seq[14:0], clk_out}; end
      chk("t3_seq", seq[7:0], 8'b00111000);

      // Two loads in one period yield one ack; new period 10.
      acks = 0;
      cyc(1, 1, 8);
      cyc(1, 1, 10);
      seq = '0;
      for (int i = 0; i < 14; i++) begin
         cyc(1, 0, 0);
         if (div_ack) acks++;
         seq = {seq[14:0], clk_out};
      end
      chk("t4_acks", acks, 1);

      // Clamp: 0 and 1 behave as 2.
      do_reset();
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      seq = '0;
      for (int i = 0; i < 6; i++) begin cyc(1, 0, 0); seq = {seq[14:0], clk_out}; end
      chk("t5_ratio0", seq[5:0], 6'b101010);
      cyc(0, 1, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0);
      seq = '0;
      for (int i = 0; i < 4; i++) begin cyc(1, 0, 0); seq = {seq[14:0], clk_out}; end
      chk("t5_ratio1", seq[3:0], 4'b1010);

      // Stop one cycle into HIGH at N=6, then async reset mid-HIGH.
      do_reset();
      cyc(0, 1, 6);
      cyc(0, 0, 0);
      seq = '0;
      cyc(1, 0, 0); seq = {seq[14:0], clk_out};
      for (int i = 0; i < 7; i++) begin cyc(0, 0, 0); seq = {seq[14:0], clk_out}; end
      chk("t6_stop_seq", seq[7:0], 8'b11100000);
      chk("t6_running", running, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      do_reset();
      seq = '0;
      for (int i = 0; i < 6; i++) begin cyc(1, 0, 0); seq = {seq[14:0], clk_out}; end
      chk("t6_restart", seq[5:0], 6'b110011);

      // Randomized traffic against the reference model.
      e_r = 1;
      for (int i = 0; i < 3000; i++) begin
         int r;
         bit ld;
         if ($urandom_range(0, 15) == 0) e_r = ~e_r;
         ld = ($urandom_range(0, 9) == 0);
         r  = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 12) : $urandom_range(0, 255);
         if ($urandom_range(0, 499) == 0) do_reset();
         else cyc(e_r, ld, r);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
